// File: rtl/time_syn_pkg.sv
// Shared definitions for the time-sync frame transmitter and receiver.
// Frame layout constants, type codes and receiver state encoding.
package time_syn_pkg;

    localparam int          P_FRAME_LEN = 8;
    localparam logic [15:0] P_MAGIC     = 16'hA55A;
    localparam logic [7:0]  P_TYPE_TS   = 8'h01;
    localparam logic [7:0]  P_TYPE_RET  = 8'h02;
    localparam logic [7:0]  P_TYPE_STD  = 8'h03;

    localparam int BEAT_HDR  = 0;
    localparam int BEAT_TIME = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TIME,
        S_PAD,
        S_DROP
    } rx_state_t;

    typedef enum logic [1:0] {
        F_NONE,
        F_TS,
        F_RET,
        F_STD
    } frame_kind_t;

    function automatic frame_kind_t decode_type(input logic [7:0] t);
        case (t)
            P_TYPE_TS:  return F_TS;
            P_TYPE_RET: return F_RET;
            P_TYPE_STD: return F_STD;
            default:    return F_NONE;
        endcase
    endfunction

endpackage

// File: rtl/time_syn_frame_rx.sv
// Time-sync frame receiver: validates 8-beat AXIS frames and
// publishes the carried 64-bit time per frame type.
module time_syn_frame_rx
    import time_syn_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx_axis_tvalid,
    input  logic [63:0] i_rx_axis_tdata,
    input  logic        i_rx_axis_tlast,
    input  logic [7:0]  i_rx_axis_tkeep,
    input  logic        i_rx_axis_tuser,
    output logic [63:0] o_recv_time_stamp,
    output logic        o_recv_ts_valid,
    output logic [63:0] o_recv_return_ts,
    output logic        o_recv_return_valid,
    output logic [63:0] o_recv_std_time,
    output logic        o_recv_std_valid,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_err_cnt
);

    logic        r_valid;
    logic [63:0] r_data;
    logic        r_last;
    logic [7:0]  r_keep;
    logic        r_user;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_keep  <= '0;
            r_user  <= 1'b0;
        end else begin
            r_valid <= i_rx_axis_tvalid;
            r_data  <= i_rx_axis_tdata;
            r_last  <= i_rx_axis_tlast;
            r_keep  <= i_rx_axis_tkeep;
            r_user  <= i_rx_axis_tuser;
        end
    end

    rx_state_t   state;
    frame_kind_t kind;
    frame_kind_t commit_kind;
    frame_kind_t hdr_kind;
    logic [3:0]  cnt;
    logic [63:0] hold;
    logic        commit;
    logic        keep_ok;
    logic        hdr_ok;
    logic        pad_good;
    logic        bad;

    // bad marks the single beat on which a rejected frame is counted
    always_comb begin
        keep_ok  = (r_keep == 8'hFF);
        hdr_kind = decode_type(r_data[47:40]);
        hdr_ok   = (r_data[63:48] == P_MAGIC) && (hdr_kind != F_NONE)
                   && keep_ok && !r_last;
        pad_good = r_last && (cnt == 4'(P_FRAME_LEN - 1))
                   && keep_ok && !r_user;
        bad      = 1'b0;
        if (r_valid) begin
            case (state)
                S_IDLE:  bad = r_last && !hdr_ok;
                S_TIME:  bad = r_last;
                S_PAD:   bad = r_last && !pad_good;
                S_DROP:  bad = r_last;
                default: bad = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            kind        <= F_NONE;
            commit_kind <= F_NONE;
            cnt         <= 4'(BEAT_HDR);
            hold        <= '0;
            commit      <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (r_valid) begin
                case (state)
                    S_IDLE: begin
                        if (hdr_ok) begin
                            kind  <= hdr_kind;
                            cnt   <= 4'(BEAT_TIME);
                            state <= S_TIME;
                        end else if (!r_last) begin
                            state <= S_DROP;
                        end
                    end
                    S_TIME: begin
                        hold <= r_data;
                        cnt  <= 4'(BEAT_TIME + 1);
                        if (r_last)
                            state <= S_IDLE;
                        else if (!keep_ok)
                            state <= S_DROP;
                        else
                            state <= S_PAD;
                    end
                    S_PAD: begin
                        if (r_last) begin
                            state       <= S_IDLE;
                            commit      <= pad_good;
                            commit_kind <= kind;
                        end else if (!keep_ok
                                     || cnt == 4'(P_FRAME_LEN - 1)) begin
                            state <= S_DROP;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    S_DROP: begin
                        if (r_last)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    logic [63:0] ts_time;
    logic [63:0] ret_time;
    logic [63:0] std_time;
    logic        ts_valid;
    logic        ret_valid;
    logic        std_valid;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts_time   <= '0;
            ret_time  <= '0;
            std_time  <= '0;
            ts_valid  <= 1'b0;
            ret_valid <= 1'b0;
            std_valid <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            ts_valid  <= 1'b0;
            ret_valid <= 1'b0;
            std_valid <= 1'b0;
            if (commit) begin
                frame_cnt <= frame_cnt + 16'd1;
                case (commit_kind)
                    F_TS: begin
                        ts_time  <= hold;
                        ts_valid <= 1'b1;
                    end
                    F_RET: begin
                        ret_time  <= hold;
                        ret_valid <= 1'b1;
                    end
                    F_STD: begin
                        std_time  <= hold;
                        std_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (bad && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

    assign o_recv_time_stamp   = ts_time;
    assign o_recv_ts_valid     = ts_valid;
    assign o_recv_return_ts    = ret_time;
    assign o_recv_return_valid = ret_valid;
    assign o_recv_std_time     = std_time;
    assign o_recv_std_valid    = std_valid;
    assign o_frame_cnt         = frame_cnt;
    assign o_err_cnt           = err_cnt;

endmodule

// File: tb/tb_time_syn_frame_rx.sv
// Bench for time_syn_frame_rx: directed table, corner sequences and
// random frames checked against a frame-level reference model.
module tb_time_syn_frame_rx;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        tvalid = 1'b0;
    logic [63:0] tdata  = '0;
    logic        tlast  = 1'b0;
    logic [7:0]  tkeep  = '0;
    logic        tuser  = 1'b0;

    logic [63:0] recv_ts;
    logic        ts_v;
    logic [63:0] recv_ret;
    logic        ret_v;
    logic [63:0] recv_std;
    logic        std_v;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    time_syn_frame_rx dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_rx_axis_tvalid    (tvalid),
        .i_rx_axis_tdata     (tdata),
        .i_rx_axis_tlast     (tlast),
        .i_rx_axis_tkeep     (tkeep),
        .i_rx_axis_tuser     (tuser),
        .o_recv_time_stamp   (recv_ts),
        .o_recv_ts_valid     (ts_v),
        .o_recv_return_ts    (recv_ret),
        .o_recv_return_valid (ret_v),
        .o_recv_std_time     (recv_std),
        .o_recv_std_valid    (std_v),
        .o_frame_cnt         (frame_cnt),
        .o_err_cnt           (err_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // v = {ts, ret, std}
    typedef struct packed {
        logic [2:0]  v;
        logic [63:0] t;
    } exp_t;

    exp_t        exp_q[int];
    exp_t        mon_e;
    logic [15:0] m_frame;
    logic [15:0] m_err;
    logic [63:0] m_ts;
    logic [63:0] m_ret;
    logic [63:0] m_std;

    logic [63:0] fb_data[16];
    logic [7:0]  fb_keep[16];
    int          fb_len;
    logic        fb_user;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_e = '0;
            if (exp_q.exists(cyc)) begin
                mon_e = exp_q[cyc];
                exp_q.delete(cyc);
            end
            chk("valid_pulse", {61'd0, ts_v, ret_v, std_v},
                {61'd0, mon_e.v});
            if (mon_e.v[2]) chk("ts_data", recv_ts, mon_e.t);
            if (mon_e.v[1]) chk("ret_data", recv_ret, mon_e.t);
            if (mon_e.v[0]) chk("std_data", recv_std, mon_e.t);
        end
    end

    task automatic put(input logic [63:0] d, input logic l,
                       input logic [7:0] k, input logic u);
        @(negedge clk);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        tkeep  = k;
        tuser  = u;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tvalid = 1'b0;
            tdata  = {$urandom, $urandom};
            tlast  = 1'($urandom);
            tkeep  = 8'($urandom);
            tuser  = 1'($urandom);
        end
    endtask

    task automatic build(input logic [7:0] typ, input logic [63:0] tm,
                         input logic [15:0] magic, input int len);
        fb_len  = len;
        fb_user = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fb_data[i] = {$urandom, $urandom};
            fb_keep[i] = 8'hFF;
        end
        fb_data[0] = {magic, typ, 40'd0};
        fb_data[1] = tm;
    endtask

    function automatic bit classify();
        bit ok;
        ok = (fb_len == 8) && (fb_data[0][63:48] == 16'hA55A)
             && (fb_data[0][47:40] inside {8'h01, 8'h02, 8'h03})
             && !fb_user;
        for (int i = 0; i < fb_len; i++)
            if (fb_keep[i] != 8'hFF) ok = 1'b0;
        return ok;
    endfunction

    // Called in the cycle the tlast beat is driven.
    task automatic note(input bit good);
        exp_t e;
        e = '0;
        if (good) begin
            e.t = fb_data[1];
            case (fb_data[0][47:40])
                8'h01: begin e.v = 3'b100; m_ts  = fb_data[1]; end
                8'h02: begin e.v = 3'b010; m_ret = fb_data[1]; end
                default: begin e.v = 3'b001; m_std = fb_data[1]; end
            endcase
            exp_q[cyc + 3] = e;
            m_frame = m_frame + 16'd1;
        end else if (m_err != 16'hFFFF) begin
            m_err = m_err + 16'd1;
        end
    endtask

    task automatic send(input bit good, input int gap_at, input int gap_len);
        for (int i = 0; i < fb_len; i++) begin
            if (i == gap_at) idle(gap_len);
            put(fb_data[i], 1'(i == fb_len - 1), fb_keep[i],
                (i == fb_len - 1) ? fb_user : 1'b0);
        end
        note(good);
    endtask

    task automatic settle(input string tag);
        idle(5);
        chk({tag, "_frame_cnt"}, {48'd0, frame_cnt}, {48'd0, m_frame});
        chk({tag, "_err_cnt"}, {48'd0, err_cnt}, {48'd0, m_err});
        chk({tag, "_ts"}, recv_ts, m_ts);
        chk({tag, "_ret"}, recv_ret, m_ret);
        chk({tag, "_std"}, recv_std, m_std);
    endtask

    typedef struct {
        logic [7:0]  typ;
        logic [63:0] tm;
        logic [15:0] magic;
        int          len;
        int          keep_at;
        logic        user;
        int          gap_at;
        bit          good;
    } row_t;

    row_t tbl[12];

    initial begin
        m_frame = '0;
        m_err   = '0;
        m_ts    = '0;
        m_ret   = '0;
        m_std   = '0;

        tbl[0]  = '{8'h03, 64'h0000_0001_2345_6789, 16'hA55A, 8, -1, 1'b0, -1, 1'b1};
        tbl[1]  = '{8'h01, 64'h0BAD_0001, 16'hA55B, 8, -1, 1'b0, -1, 1'b0};
        tbl[2]  = '{8'h01, 64'h0BAD_0002, 16'hA55A, 6, -1, 1'b0, -1, 1'b0};
        tbl[3]  = '{8'h03, 64'h0BAD_0003, 16'hA55A, 8, -1, 1'b1, -1, 1'b0};
        tbl[4]  = '{8'h02, 64'h0BAD_0004, 16'hA55A, 8, 3, 1'b0, -1, 1'b0};
        tbl[5]  = '{8'h01, 64'h0BAD_0005, 16'hA55A, 10, -1, 1'b0, -1, 1'b0};
        tbl[6]  = '{8'h03, 64'h0000_CAFE_F00D, 16'hA55A, 8, -1, 1'b0, 2, 1'b1};
        tbl[7]  = '{8'h04, 64'h0BAD_0007, 16'hA55A, 8, -1, 1'b0, -1, 1'b0};
        tbl[8]  = '{8'h01, 64'h0BAD_0008, 16'hA55A, 1, -1, 1'b0, -1, 1'b0};
        tbl[9]  = '{8'h01, 64'h1111_1111, 16'hA55A, 8, -1, 1'b0, -1, 1'b1};
        tbl[10] = '{8'h02, 64'h2222_2222, 16'hA55A, 8, -1, 1'b0, -1, 1'b1};
        tbl[11] = '{8'h02, 64'h0BAD_000B, 16'hA55A, 7, 7, 1'b0, -1, 1'b0};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ts", recv_ts, 64'd0);
        chk("rst_valids", {61'd0, ts_v, ret_v, std_v}, 64'd0);
        chk("rst_cnts", {32'd0, frame_cnt, err_cnt}, 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        settle("reset");

        for (int r = 0; r < 12; r++) begin
            build(tbl[r].typ, tbl[r].tm, tbl[r].magic, tbl[r].len);
            if (tbl[r].keep_at >= 0) fb_keep[tbl[r].keep_at] = 8'h0F;
            fb_user = tbl[r].user;
            send(tbl[r].good, tbl[r].gap_at, 3);
            settle($sformatf("row%0d", r));
        end

        // Zero-gap TS then RET frames.
        build(8'h01, 64'h10, 16'hA55A, 8);
        send(1'b1, -1, 0);
        build(8'h02, 64'h20, 16'hA55A, 8);
        send(1'b1, -1, 0);
        settle("b2b");

        // Reset across beats 4..5 of a TS frame, padding beats zeroed.
        build(8'h01, 64'h55, 16'hA55A, 8);
        for (int i = 2; i < 8; i++) fb_data[i] = '0;
        for (int i = 0; i < 4; i++) put(fb_data[i], 1'b0, 8'hFF, 1'b0);
        @(negedge clk);
        rst_n  = 1'b0;
        tdata  = fb_data[4];
        exp_q.delete();
        m_frame = '0;
        m_err   = '0;
        m_ts    = '0;
        m_ret   = '0;
        m_std   = '0;
        #2;
        chk("mid_rst_ts", recv_ts, 64'd0);
        chk("mid_rst_valids", {61'd0, ts_v, ret_v, std_v}, 64'd0);
        chk("mid_rst_cnts", {32'd0, frame_cnt, err_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tdata = fb_data[5];
        put(fb_data[6], 1'b0, 8'hFF, 1'b0);
        put(fb_data[7], 1'b1, 8'hFF, 1'b0);
        m_err = 16'd1;
        settle("post_rst");
        build(8'h01, 64'h77, 16'hA55A, 8);
        send(1'b1, -1, 0);
        settle("post_rst_good");

        // Random frames against the frame-level model.
        for (int n = 0; n < 80; n++) begin
            logic [7:0]  typ;
            logic [15:0] mg;
            int          len;
            int          gap_at;
            typ = 8'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) typ = 8'($urandom_range(0, 7));
            mg = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'hA55A;
            len = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 11) : 8;
            build(typ, {$urandom, $urandom}, mg, len);
            if ($urandom_range(0, 9) == 0)
                fb_keep[$urandom_range(0, len - 1)] = 8'($urandom_range(0, 254));
            if ($urandom_range(0, 9) == 0) fb_user = 1'b1;
            gap_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : -1;
            send(classify(), gap_at, $urandom_range(1, 4));
            idle($urandom_range(0, 2));
        end
        settle("random");

        // Error counter saturation.
        @(negedge clk);
        force dut.err_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.err_cnt;
        m_err = 16'hFFFE;
        idle(1);
        chk("sat_preload", {48'd0, err_cnt}, 64'hFFFE);
        for (int k = 0; k < 3; k++) begin
            build(8'h03, 64'h0BAD_5A70, 16'hA55B, 8);
            send(1'b0, -1, 0);
            settle($sformatf("sat%0d", k));
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_syn_frame_rx.md
Name: time_syn_frame_rx

Overview:
- Receive-side decoder for the time-sync protocol; the counterpart of the time-sync frame transmitter.
- Sits between the MAC RX AXI-Stream (64-bit, no backpressure) and the time-sync master/slave FSMs.
- Validates fixed 8-beat frames and extracts the 64-bit time field.
- Emits one-cycle valid pulses per frame type: slave timestamp, returned timestamp, standard time.

Parameters:
- P_FRAME_LEN, 8, beats per frame; the last beat carries tlast.
- P_MAGIC, 16'hA55A, header magic in beat0[63:48].
- P_TYPE_TS, 8'h01, slave-to-master timestamp frame.
- P_TYPE_RET, 8'h02, master-returned timestamp frame.
- P_TYPE_STD, 8'h03, master standard-time frame.

Ports:
- i_clk  in  1  single clock, MAC RX user clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_rx_axis_tvalid  in  1  beat valid; no tready exists, so the block must accept every beat.
- i_rx_axis_tdata  in  64  beat data.
- i_rx_axis_tlast  in  1  last beat of frame.
- i_rx_axis_tkeep  in  8  byte enables; 8'hFF is required on every beat.
- i_rx_axis_tuser  in  1  MAC error flag; 1 on the tlast beat marks a bad frame.
- o_recv_time_stamp  out  64  time field of the last good TS frame.
- o_recv_ts_valid  out  1  one-cycle pulse.
- o_recv_return_ts  out  64  time field of the last good RET frame.
- o_recv_return_valid  out  1  one-cycle pulse.
- o_recv_std_time  out  64  time field of the last good STD frame.
- o_recv_std_valid  out  1  one-cycle pulse.
- o_frame_cnt  out  16  count of good frames; wraps.
- o_err_cnt  out  16  count of rejected frames; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, beat counter 0.
- Frame format:
  - beat0 = {P_MAGIC, type[7:0], 40'd0}
  - beat1 = 64-bit time value
  - beats 2..7 = padding, content ignored
- Input stage: every AXIS input is registered once (r_*), and the FSM works on the registered beat.
- FSM states:
  - IDLE: on a valid beat, check magic, type ∈ {TS, RET, STD}, tkeep == FF and tlast == 0.
    - All pass: latch type and go to TIME.
    - Any fail: go to DROP. If that beat also has tlast, count the error and stay in IDLE.
  - TIME: on a valid beat, latch tdata into a holding register and go to PAD with beat count 2.
    - tlast or bad tkeep: error; tlast returns to IDLE, otherwise go to DROP.
  - PAD: increment the beat count on each valid beat.
    - tlast at count == P_FRAME_LEN-1 with tkeep == FF and tuser == 0: frame is good; go to IDLE.
    - tlast early, tuser == 1, or bad tkeep: error; go to IDLE (or DROP if tlast is absent).
    - Count reaches P_FRAME_LEN-1 without tlast: oversize; go to DROP.
  - DROP: discard beats until tlast, then count one error and return to IDLE. A frame is counted as an error exactly once.
- Good-frame commit, one cycle after the registered tlast beat:
  - Load the holding value into the output register selected by type.
  - Pulse that type's valid for exactly one cycle; the other valids stay 0.
  - Increment o_frame_cnt.
- Latency: the valid pulse is asserted 2 cycles after the input tlast beat. Consumers compensate by exactly 2 cycles, and this is fixed.
- Output data registers hold their value until the next good frame of the same type. Rejected frames never alter them.
- Gaps: tvalid = 0 mid-frame is allowed; state and count hold and there is no timeout.
- Back-to-back frames: beat0 of the next frame may arrive in the cycle after tlast, and is parsed while the commit of the previous frame occurs.
- Reset released mid-frame: the first beat seen fails the magic check, so the block drops until tlast with one error counted. A body beat that happens to match the magic is resolved by the length and tlast checks.
- o_err_cnt at 16'hFFFF stays at 16'hFFFF.

Decomposition:
- Package time_syn_pkg holds P_MAGIC, the P_TYPE_* codes, P_FRAME_LEN, and the beat-index constants (header 0, time 1). It is shared with the transmitter and the FSM module.
- No sub-module; the input register stage, FSM and counters live in one file.

Test Plan:
- Good STD frame, time 64'h0000_0001_2345_6789, contiguous beats:
  - o_recv_std_valid pulses once, 2 cycles after tlast.
  - o_recv_std_time = 64'h0000_0001_2345_6789; o_frame_cnt = 1; other valids stay 0.
- Back-to-back TS frame (time 64'h10), then RET frame (time 64'h20), zero gap:
  - ts_valid pulses with 64'h10; return_valid pulses 8 cycles later with 64'h20.
  - o_frame_cnt = 2.
- Errors, tested separately:
  - magic 16'hA55B;
  - tlast on beat 5;
  - tuser = 1 on beat 7;
  - tkeep = 8'h0F on beat 3;
  - 10-beat frame.
  - Required response for each: no valid pulse, o_err_cnt increments by exactly 1, and the previous output data is unchanged.
- STD frame with tvalid deasserted for 3 cycles between beats 1 and 2: good frame; valid pulses 2 cycles after tlast.
- i_rst_n asserted on beat 4 and released on beat 5 of a TS frame:
  - All outputs 0 during reset.
  - Residual beats count err_cnt = 1.
  - The following good frame decodes correctly.
- Force o_err_cnt to 16'hFFFE, then inject 3 bad frames: the counter reads 16'hFFFF and holds.
